// File: rtl/fetch_decode_stage_pkg.sv
// Shared RV32I front-end constants: opcode encodings, NOP forms and D_out field positions.
// Also imported by the pipeline controller.
package fetch_decode_stage_pkg;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP_IMM = 5'b00100;
    localparam logic [4:0] OP_R_TYPE = 5'b01100;
    localparam logic [4:0] OP_NOP    = OP_OP_IMM;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [23:0] NOP_BUNDLE = {19'd0, OP_NOP};

    localparam int DOUT_F7      = 23;
    localparam int DOUT_RS2_LSB = 18;
    localparam int DOUT_RS1_LSB = 13;
    localparam int DOUT_F3_LSB  = 10;
    localparam int DOUT_RD_LSB  = 5;
    localparam int DOUT_OP_LSB  = 0;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_class_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        logic legal;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OP_IMM, OP_R_TYPE: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic imm_class_e imm_class(input logic [4:0] op);
        imm_class_e cls;
        case (op)
            OP_LOAD, OP_OP_IMM, OP_JALR: cls = IMM_I;
            OP_STORE:                    cls = IMM_S;
            OP_BRANCH:                   cls = IMM_B;
            OP_LUI, OP_AUIPC:            cls = IMM_U;
            OP_JAL:                      cls = IMM_J;
            default:                     cls = IMM_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/fetch_decode_stage_imm_gen.sv
// Immediate generator: sign-extended immediate selected by the instruction's format class.
// Unsupported encodings (including non-32-bit low bits) yield zero.
module fetch_decode_stage_imm_gen
    import fetch_decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Format-dependent immediate assembly
    always_comb begin
        imm = 32'd0;
        if (inst[1:0] == 2'b11) begin
            case (imm_class(inst[6:2]))
                IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
                IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                IMM_U:   imm = {inst[31:12], 12'd0};
                IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                default: imm = 32'd0;
            endcase
        end else begin
            imm = 32'd0;
        end
    end

endmodule

// File: rtl/fetch_decode_stage.sv
// RV32I fetch/decode front end: PC register, IF/ID register and field decode.
// Only F_pc, D_inst and D_pc are state; every D_* output is combinational decode.
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            next_pc_sel,
    input  logic [XLEN-1:0] jb_pc,
    output logic [XLEN-1:0] im_addr,
    input  logic [31:0]     im_rdata,
    output logic [XLEN-1:0] F_pc,
    output logic [XLEN-1:0] D_pc,
    output logic [31:0]     D_inst,
    output logic [23:0]     D_out,
    output logic [31:0]     D_imm,
    output logic [4:0]      D_rs1_index,
    output logic [4:0]      D_rs2_index,
    output logic            D_illegal
);

    logic [XLEN-1:0] f_pc_r;
    logic [XLEN-1:0] d_pc_r;
    logic [31:0]     d_inst_r;

    logic [4:0]  op_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [2:0]  f3_s;
    logic        f7_s;
    logic        legal_s;
    logic [23:0] bundle_s;
    logic [31:0] imm_s;

    // PC and IF/ID register: stall holds, redirect squashes decode, otherwise advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_pc_r   <= RESET_PC;
            d_inst_r <= NOP_INST;
            d_pc_r   <= 32'd0;
        end else if (stall) begin
            f_pc_r   <= f_pc_r;
            d_inst_r <= d_inst_r;
            d_pc_r   <= d_pc_r;
        end else if (!next_pc_sel) begin
            f_pc_r   <= jb_pc;
            d_inst_r <= NOP_INST;
            d_pc_r   <= 32'd0;
        end else begin
            f_pc_r   <= f_pc_r + 32'd4;
            d_inst_r <= im_rdata;
            d_pc_r   <= f_pc_r;
        end
    end

    // Field extraction with per-format zeroing of unused register fields
    always_comb begin
        op_s     = d_inst_r[6:2];
        f3_s     = d_inst_r[14:12];
        legal_s  = (d_inst_r[1:0] == 2'b11) && is_legal_op(op_s);
        rd_s     = d_inst_r[11:7];
        rs1_s    = d_inst_r[19:15];
        rs2_s    = 5'd0;
        f7_s     = 1'b0;
        bundle_s = NOP_BUNDLE;

        if ((op_s == OP_LUI) || (op_s == OP_AUIPC) || (op_s == OP_JAL)) begin
            rs1_s = 5'd0;
        end else begin
            rs1_s = d_inst_r[19:15];
        end

        if ((op_s == OP_R_TYPE) || (op_s == OP_STORE) || (op_s == OP_BRANCH)) begin
            rs2_s = d_inst_r[24:20];
        end else begin
            rs2_s = 5'd0;
        end

        if ((op_s == OP_STORE) || (op_s == OP_BRANCH)) begin
            rd_s = 5'd0;
        end else begin
            rd_s = d_inst_r[11:7];
        end

        // inst[30] only distinguishes SUB/SRA and SRAI from their siblings
        if ((op_s == OP_R_TYPE) || ((op_s == OP_OP_IMM) && (f3_s == 3'b101))) begin
            f7_s = d_inst_r[30];
        end else begin
            f7_s = 1'b0;
        end

        if (legal_s) begin
            bundle_s                          = 24'd0;
            bundle_s[DOUT_F7]                 = f7_s;
            bundle_s[DOUT_RS2_LSB +: 5]       = rs2_s;
            bundle_s[DOUT_RS1_LSB +: 5]       = rs1_s;
            bundle_s[DOUT_F3_LSB  +: 3]       = f3_s;
            bundle_s[DOUT_RD_LSB  +: 5]       = rd_s;
            bundle_s[DOUT_OP_LSB  +: 5]       = op_s;
        end else begin
            bundle_s = NOP_BUNDLE;
        end
    end

    fetch_decode_stage_imm_gen u_imm_gen (
        .inst (d_inst_r),
        .imm  (imm_s)
    );

    assign im_addr     = f_pc_r;
    assign F_pc        = f_pc_r;
    assign D_pc        = d_pc_r;
    assign D_inst      = d_inst_r;
    assign D_out       = bundle_s;
    assign D_imm       = imm_s;
    assign D_rs1_index = bundle_s[DOUT_RS1_LSB +: 5];
    assign D_rs2_index = bundle_s[DOUT_RS2_LSB +: 5];
    assign D_illegal   = ~legal_s;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a PC/IF-ID model pushes expected decode results
// to a queue on every driven cycle; they are popped and checked one clock later.
module tb_fetch_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        next_pc_sel;
    logic [31:0] jb_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_inst;
    logic [23:0] D_out;
    logic [31:0] D_imm;
    logic [4:0]  D_rs1_index;
    logic [4:0]  D_rs2_index;
    logic        D_illegal;

    fetch_decode_stage #(.RESET_PC(RPC), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .next_pc_sel (next_pc_sel),
        .jb_pc       (jb_pc),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .F_pc        (F_pc),
        .D_pc        (D_pc),
        .D_inst      (D_inst),
        .D_out       (D_out),
        .D_imm       (D_imm),
        .D_rs1_index (D_rs1_index),
        .D_rs2_index (D_rs2_index),
        .D_illegal   (D_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dpc;
        logic [31:0] dinst;
        logic [23:0] dout;
        logic [31:0] dimm;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] m_pc;
    logic [31:0] m_dpc;
    logic [31:0] m_dinst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image; unmapped addresses read as NOP
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h00A2_8293; // addi x5,x5,10
            32'h0000_0104: return 32'hFE00_08E3; // beq x0,x0,-16
            32'h0000_0108: return 32'h0020_81B3; // add x3,x1,x2
            32'h0000_010C: return 32'h4020_81B3; // sub x3,x1,x2
            32'h0000_0110: return 32'h4033_D313; // srai x6,x7,3
            32'h0000_0114: return 32'hFE51_2E23; // sw x5,-4(x2)
            32'h0000_0118: return 32'h1234_5537; // lui x10,0x12345
            32'h0000_011C: return 32'h0080_00EF; // jal x1,+8
            32'h0000_0120: return 32'h0000_000F; // fence
            32'h0000_0124: return 32'h00A2_8290; // low bits 00: compressed space
            32'h0000_0200: return 32'h4020_81B3; // sub x3,x1,x2
            32'hFFFF_FFFC: return 32'hFE51_2E23; // sw x5,-4(x2)
            default:       return NOP;
        endcase
    endfunction

    always_comb im_rdata = mem_word(im_addr);

    // Hand-decoded reference values for every word in the image
    task automatic ref_decode(input logic [31:0] inst, output logic [23:0] dout,
                              output logic [31:0] imm, output logic ill);
        ill = 1'b0;
        case (inst)
            32'h0000_0013: begin dout = 24'h000004; imm = 32'h0000_0000; end
            32'h00A2_8293: begin dout = 24'h00A0A4; imm = 32'h0000_000A; end
            32'hFE00_08E3: begin dout = 24'h000018; imm = 32'hFFFF_FFF0; end
            32'h0020_81B3: begin dout = 24'h08206C; imm = 32'h0000_0000; end
            32'h4020_81B3: begin dout = 24'h88206C; imm = 32'h0000_0000; end
            32'h4033_D313: begin dout = 24'h80F4C4; imm = 32'h0000_0403; end
            32'hFE51_2E23: begin dout = 24'h144808; imm = 32'hFFFF_FFFC; end
            32'h1234_5537: begin dout = 24'h00154D; imm = 32'h1234_5000; end
            32'h0080_00EF: begin dout = 24'h00003B; imm = 32'h0000_0008; end
            32'h0000_000F: begin dout = 24'h000004; imm = 32'h0000_0000; ill = 1'b1; end
            32'h00A2_8290: begin dout = 24'h000004; imm = 32'h0000_0000; ill = 1'b1; end
            default:       begin dout = 24'hxxxxxx; imm = 32'hxxxx_xxxx; ill = 1'bx; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc    = m_pc;
        e.dpc   = m_dpc;
        e.dinst = m_dinst;
        ref_decode(m_dinst, e.dout, e.dimm, e.ill);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("im_addr",   im_addr,              e.pc);
            chk("F_pc",      F_pc,                 e.pc);
            chk("D_pc",      D_pc,                 e.dpc);
            chk("D_inst",    D_inst,               e.dinst);
            chk("D_out",     {8'd0, D_out},        {8'd0, e.dout});
            chk("D_imm",     D_imm,                e.dimm);
            chk("D_illegal", {31'd0, D_illegal},   {31'd0, e.ill});
            chk("D_rs1",     {27'd0, D_rs1_index}, {27'd0, e.dout[17:13]});
            chk("D_rs2",     {27'd0, D_rs2_index}, {27'd0, e.dout[22:18]});
        end
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_dinst = NOP;
        m_dpc   = 32'd0;
    endtask

    task automatic cycle(input logic s, input logic sel, input logic [31:0] jb);
        stall       = s;
        next_pc_sel = sel;
        jb_pc       = jb;
        if (s) begin
            m_pc = m_pc;
        end else if (!sel) begin
            m_dinst = NOP;
            m_dpc   = 32'd0;
            m_pc    = jb;
        end else begin
            m_dinst = mem_word(m_pc);
            m_dpc   = m_pc;
            m_pc    = m_pc + 32'd4;
        end
        push_exp();
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        next_pc_sel = 1'b1;
        jb_pc       = 32'd0;
        #12;
        model_reset();
        push_exp();
        check_out();
        rst = 1'b0;

        // sequential fetch and decode of several formats
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd0);

        // two-cycle stall, then stall together with a redirect request
        cycle(1'b1, 1'b1, 32'd0);
        cycle(1'b1, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 32'h0000_0300);

        // resume without loss or duplication
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 32'd0);
        end

        // taken branch: squash, then target reaches decode
        cycle(1'b0, 1'b0, 32'h0000_0200);
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd0);

        // PC wrap at the top of the address space
        cycle(1'b0, 1'b0, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd0);

        // asynchronous reset mid-run, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp();
        check_out();
        rst = 1'b0;
        cycle(1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b1, 32'd0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
